// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Imported by the queue, the stage top and the bench.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage boundary: memory bus, ALU redirect and decode handshake.
// master = fetch stage, slave = memory/ALU/decode environment.
interface fetch_if;
    logic        mem_busy;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;

    modport master (
        input  mem_busy, imem_gnt, imem_rvalid, imem_rdata,
               redirect_valid, redirect_pc, if_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus_4
    );

    modport slave (
        output mem_busy, imem_gnt, imem_rvalid, imem_rdata,
               redirect_valid, redirect_pc, if_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus_4
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular prefetch queue: allocate on issue, fill on response, pop to decode.
// Latency: a fill is visible at the head the cycle after it is written.
// Backpressure: caller must not allocate when full nor pop an empty head; flush wins.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         alloc_vld,
    input  logic [31:0]  alloc_pc,
    input  logic         fill_vld,
    input  logic [31:0]  fill_dat,
    input  logic         pop_vld,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] pend_cnt
);

    fetch_entry_t  entries_q [DEPTH];
    fetch_entry_t  entries_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] fill_ptr_q, fill_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pend_q, pend_d;
    logic          bypass_pop;

    assign head     = entries_q[rd_ptr_q];
    assign count    = count_q;
    assign pend_cnt = pend_q;

    // Popping an unfilled head means the caller forwarded the response directly.
    assign bypass_pop = pop_vld & fill_vld & ~entries_q[rd_ptr_q].filled;

    always_comb begin
        entries_d  = entries_q;
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pend_d     = pend_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].filled = 1'b0;
            end
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            pend_d     = '0;
        end else begin
            if (alloc_vld) begin
                entries_d[wr_ptr_q].pc     = alloc_pc;
                entries_d[wr_ptr_q].filled = 1'b0;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (fill_vld) begin
                if (!bypass_pop) begin
                    entries_d[fill_ptr_q].instr  = fill_dat;
                    entries_d[fill_ptr_q].filled = 1'b1;
                end
                fill_ptr_d = fill_ptr_q + AW'(1);
            end
            if (pop_vld) begin
                entries_d[rd_ptr_q].filled = 1'b0;
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(alloc_vld) - CW'(pop_vld);
            pend_d  = pend_q + CW'(alloc_vld) - CW'(fill_vld);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pend_q     <= '0;
        end else begin
            entries_q  <= entries_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: in-order word reads, prefetch queue, redirect flush. FETCH_BYPASS_EN forwards rdata.
// Latency: 1 cycle rvalid->if_valid (0 with FETCH_BYPASS_EN).
// Backpressure: if_ready low holds outputs; issue stops once queued + dropped reaches DEPTH.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic      clk,
    input logic      reset,
    fetch_if.master  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fpc_q, fpc_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]   hold_pc_q, hold_pc_d;
    logic [31:0]   hold_pc4_q, hold_pc4_d;
    logic [31:0]   hold_instr_q, hold_instr_d;

    fetch_entry_t  head;
    logic [CW-1:0] q_count;
    logic [CW-1:0] q_pend;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          fill_vld;
    logic          pop_vld;
    logic          bypass_hit;

    // Dropped responses still occupy a slot until they come back.
    assign occupancy     = {1'b0, q_count} + {1'b0, drop_cnt_q};
    assign bus.imem_req  = reset & ~bus.mem_busy & ~bus.redirect_valid
                         & (occupancy < (CW+1)'(DEPTH));
    assign bus.imem_addr = fpc_q;
    assign issue         = bus.imem_req & bus.imem_gnt;

    assign rsp_keep = bus.imem_rvalid & (drop_cnt_q == '0);
    assign rsp_drop = bus.imem_rvalid & (drop_cnt_q != '0);
    assign fill_vld = rsp_keep & ~bus.redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = rsp_keep & ~head.filled & (q_count != '0);
`else
    assign bypass_hit = 1'b0;
`endif

    assign bus.if_valid     = head.filled | bypass_hit;
    assign pop_vld          = bus.if_valid & bus.if_ready & ~bus.redirect_valid;
    assign bus.if_pc        = bus.if_valid ? head.pc : hold_pc_q;
    assign bus.if_pc_plus_4 = bus.if_valid ? (head.pc + PC_STEP) : hold_pc4_q;
    assign bus.if_instr     = head.filled ? head.instr
                            : (bypass_hit ? bus.imem_rdata : hold_instr_q);

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .alloc_vld (issue),
        .alloc_pc  (fpc_q),
        .fill_vld  (fill_vld),
        .fill_dat  (bus.imem_rdata),
        .pop_vld   (pop_vld),
        .head      (head),
        .count     (q_count),
        .pend_cnt  (q_pend)
    );

    always_comb begin
        fpc_d        = fpc_q;
        drop_cnt_d   = drop_cnt_q;
        hold_pc_d    = hold_pc_q;
        hold_pc4_d   = hold_pc4_q;
        hold_instr_d = hold_instr_q;
        if (bus.redirect_valid) begin
            fpc_d = {bus.redirect_pc[31:2], 2'b00};
            // Every outstanding request becomes a drop; any response this cycle retires one.
            drop_cnt_d = drop_cnt_q + q_pend - CW'(bus.imem_rvalid);
        end else begin
            if (issue) begin
                fpc_d = fpc_q + PC_STEP;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
        if (bus.if_valid) begin
            hold_pc_d    = bus.if_pc;
            hold_pc4_d   = bus.if_pc_plus_4;
            hold_instr_d = bus.if_instr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q        <= RESET_PC;
            drop_cnt_q   <= '0;
            hold_pc_q    <= '0;
            hold_pc4_q   <= '0;
            hold_instr_q <= '0;
        end else begin
            fpc_q        <= fpc_d;
            drop_cnt_q   <= drop_cnt_d;
            hold_pc_q    <= hold_pc_d;
            hold_pc4_q   <= hold_pc4_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed phases with a scoreboard of expected PCs popped by a decode-side monitor.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_if bus ();

    fetch_stage #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          issue_cnt = 0;
    int          base;
    logic        mem_hold;
    logic        granted;
    logic [31:0] gaddr;
    logic [31:0] exp_q [$];
    logic [31:0] resp_q [$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[11:0], 20'h0} | NOP_INSTR;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory: grants sampled mid-cycle, data returned in order one or more cycles later.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            granted = reset & bus.imem_req & bus.imem_gnt;
            gaddr   = bus.imem_addr;
            if (granted) issue_cnt++;
            @(posedge clk);
            #1;
            if (granted && reset) resp_q.push_back(gaddr);
            if (!reset) resp_q.delete();
            if (reset && !mem_hold && resp_q.size() > 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = instr_of(resp_q.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
            end
        end
    end

    // Decode-side monitor.
    always @(negedge clk) begin
        if (reset && bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual_pc=%h required=none", bus.if_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("if_pc", bus.if_pc, e);
                chk("if_instr", bus.if_instr, instr_of(e));
                chk("if_pc_plus_4", bus.if_pc_plus_4, e + 32'd4);
            end
        end
    end

    task automatic wait_issues(input int target);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (issue_cnt < target && n < 200);
        if (issue_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL wait_issues actual=%0d required=%0d", issue_cnt, target);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || resp_q.size() != 0 || bus.imem_rvalid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset              = 1'b0;
        mem_hold           = 1'b0;
        bus.mem_busy       = 1'b0;
        bus.imem_gnt       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_pc_plus_4", bus.if_pc_plus_4, 32'd0);

        // Streaming fetch with a mem_busy window in the middle
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) exp_q.push_back(32'(4 * i));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stream_req", 32'(bus.imem_req), 32'd1);
            chk("stream_addr", bus.imem_addr, 32'(4 * k));
`ifdef FETCH_BYPASS_EN
            if (k >= 1) chk("first_valid_latency", 32'(bus.if_valid), 32'd1);
            else        chk("first_valid_latency", 32'(bus.if_valid), 32'd0);
`else
            if (k >= 2) chk("first_valid_latency", 32'(bus.if_valid), 32'd1);
            else        chk("first_valid_latency", 32'(bus.if_valid), 32'd0);
`endif
        end
        wait_issues(6);
        bus.mem_busy = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("busy_no_req", 32'(bus.imem_req), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.mem_busy = 1'b0;
        @(negedge clk);
        chk("resume_req", 32'(bus.imem_req), 32'd1);
        chk("resume_addr", bus.imem_addr, 32'h18);
        wait_issues(12);
        bus.mem_busy = 1'b1;
        wait_drain();

        // Decode stall fills the queue to DEPTH
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.if_ready = 1'b0;
        bus.mem_busy = 1'b0;
        base = issue_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 3) chk("stall_pc_stable", bus.if_pc, 32'h0);
        end
        chk("stall_issue_count", 32'(issue_cnt - base), 32'd4);
        chk("stall_full_no_req", 32'(bus.imem_req), 32'd0);
        chk("stall_valid", 32'(bus.if_valid), 32'd1);
        chk("stall_instr", bus.if_instr, instr_of(32'h0));
        @(posedge clk);
        #1;
        bus.if_ready = 1'b1;
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("release_consecutive", 32'(bus.if_valid), 32'd1);
        end
        @(negedge clk);
        chk("release_empty", 32'(bus.if_valid), 32'd0);
        wait_drain();

        // Redirect with three requests in flight, unaligned target
        @(posedge clk);
        #1;
        mem_hold     = 1'b1;
        bus.mem_busy = 1'b0;
        base = issue_cnt;
        wait_issues(base + 3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        @(negedge clk);
        chk("redirect_no_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        mem_hold = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        base = issue_cnt;
        @(negedge clk);
        chk("redirect_req", 32'(bus.imem_req), 32'd1);
        chk("redirect_addr", bus.imem_addr, 32'h100);
        wait_issues(base + 4);
        bus.mem_busy = 1'b1;
        wait_drain();

        // Redirect coincident with an undropped response
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h20;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        mem_hold     = 1'b1;
        bus.mem_busy = 1'b0;
        base = issue_cnt;
        wait_issues(base + 2);
        bus.mem_busy = 1'b1;
        @(negedge clk);
        mem_hold = 1'b0;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        bus.mem_busy = 1'b0;
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        base = issue_cnt;
        wait_issues(base + 2);
        bus.mem_busy = 1'b1;
        wait_drain();

        // Asynchronous reset with two filled entries and two outstanding
        bus.if_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        bus.mem_busy = 1'b0;
        base = issue_cnt;
        wait_issues(base + 2);
        bus.mem_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        mem_hold     = 1'b1;
        bus.mem_busy = 1'b0;
        base = issue_cnt;
        wait_issues(base + 2);
        bus.mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("prereset_valid", 32'(bus.if_valid), 32'd1);
        chk("prereset_pc", bus.if_pc, 32'h80);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.if_valid), 32'd0);
        chk("async_rst_req", 32'(bus.imem_req), 32'd0);
        chk("async_rst_pc", bus.if_pc, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset        = 1'b1;
        mem_hold     = 1'b0;
        bus.if_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        base = issue_cnt;
        @(negedge clk);
        chk("restart_req", 32'(bus.imem_req), 32'd1);
        chk("restart_addr", bus.imem_addr, 32'h0);
        wait_issues(base + 2);
        bus.mem_busy = 1'b1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end; sits directly upstream of the decode/register stage and produces its Instr, PC and PC+4 inputs.
- Issues in-order word reads on the shared memory bus, tracks outstanding requests, buffers returned instructions in a small prefetch queue, and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects from the ALU stage by flushing the queue and discarding in-flight responses.
- Yields the bus to the data stage while a data access owns it.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2; also bounds the number of requests in flight.
RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
mem_busy  input  1  data stage owns the bus this cycle; no fetch request may be issued
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address; bits [1:0] are always 0
imem_gnt  input  1  request accepted this cycle (imem_req & imem_gnt = issue)
imem_rvalid  input  1  read data valid; responses return in issue order, at least 1 cycle after grant
imem_rdata  input  32  instruction word
redirect_valid  input  1  taken branch/jump from ALU stage
redirect_pc  input  32  new fetch PC
if_valid  output  1  if_instr/if_pc/if_pc_plus_4 are valid
if_ready  input  1  decode accepts this cycle (low = stall)
if_instr  output  32  instruction
if_pc  output  32  its PC
if_pc_plus_4  output  32  if_pc + 4

Behaviour:
- Reset (asserted low, asynchronous):
  - fpc = RESET_PC.
  - Pointers, count and drop_cnt = 0; all entry filled bits = 0.
  - imem_req = 0, if_valid = 0, and if_instr, if_pc, if_pc_plus_4 = 0.
  - Reset mid-operation abandons all in-flight requests. The memory side is reset from the same source, so no stale responses arrive afterwards.
- Queue: circular, with wr_ptr (allocate), fill_ptr (fill) and rd_ptr (pop), each $clog2(DEPTH) bits and wrapping modulo DEPTH.
  - Entry = {pc, instr, filled}.
  - count = number of allocated entries.
- Issue: imem_req = !mem_busy & !redirect_valid & (count + drop_cnt < DEPTH). imem_addr = fpc.
- On issue:
  - The entry at wr_ptr gets pc = fpc and filled = 0.
  - wr_ptr increments, count increments, fpc += 4 (32-bit wrap, no overflow flag).
- Response, when drop_cnt == 0: the entry at fill_ptr gets instr = imem_rdata and filled = 1; fill_ptr increments.
- Response, when drop_cnt > 0: the data is discarded and drop_cnt decrements.
- Output:
  - if_valid = the head entry is filled.
  - Outputs are driven from the head entry; if_pc_plus_4 = head.pc + 4.
  - Pop on if_valid & if_ready: rd_ptr increments, count decrements.
  - Latency: minimum 1 cycle from imem_rvalid to if_valid.
- Stall: while if_ready = 0, outputs are held stable. Issue continues until count + drop_cnt = DEPTH.
- Redirect (highest priority):
  - fpc <= {redirect_pc[31:2], 2'b00}.
  - All entries are invalidated; pointers and count = 0.
  - drop_cnt <= drop_cnt + (allocated-unfilled entries) - (1 if an undropped rvalid arrives this cycle, else 0). A dropped rvalid in the same cycle still decrements the old drop_cnt.
  - No issue in a redirect cycle.
  - A pop in the same cycle is ignored.
  - if_valid = 0 in the next cycle.
- Full: count + drop_cnt = DEPTH -> imem_req = 0. Pop and issue in the same cycle is allowed when the sum is below DEPTH before the pop (no same-cycle credit from the pop).
- Empty: if_valid = 0. Outputs hold their last value.
- imem_req may fall without a grant (redirect or mem_busy); the address may change on the next request.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the queue head is the entry being filled this cycle, an undropped imem_rvalid drives if_valid = 1 and if_instr = imem_rdata combinationally, giving 0-cycle latency. If if_ready is also high, the entry is popped without being written.
- Undefined: registered path only, 1-cycle minimum latency.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr; logic filled;}
  - constant NOP_INSTR = 32'h0000_0013
  - constant PC_STEP = 4
- One sub-module: fetch_queue, holding the entry storage, the three pointers, count and filled bits. It has allocate/fill/pop/flush ports.
- The fetch_stage top holds fpc, drop_cnt and the issue logic.

Test Plan:
1. Reset release, gnt=1 always, rvalid 1 cycle after each grant, if_ready=1 -> imem_addr 0,4,8,...; if_pc 0,4,8 with if_pc_plus_4 4,8,12; first if_valid 2 cycles after first grant (1 with FETCH_BYPASS_EN).
2. if_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 issues, then imem_req=0; outputs stable at pc=0; on release, pops 0,4,8,12 on consecutive cycles.
3. 3 requests in flight (pc 0x10,0x14,0x18, none returned), redirect_pc=0x103 -> next imem_addr=0x100; the next 3 rvalids are discarded; the first if_pc is 0x100.
4. redirect_valid coincident with an undropped rvalid for pc 0x20, 2 outstanding -> drop_cnt=1; the 0x20 data never appears on if_*.
5. mem_busy=1 for 5 cycles mid-stream -> imem_req=0 throughout; sequence resumes at the next PC with no gaps or duplicates.
6. Assert reset with 2 requests outstanding and 2 entries filled -> if_valid=0 and imem_req=0 immediately (asynchronous); after release, fetch restarts at RESET_PC.
